// File: rtl/vend_pkg.sv
// Shared constants for the vending payout path: state encoding, coin values
// and default widths/timeouts.
package vend_pkg;

    localparam int AMT_W_DEF   = 4;
    localparam int SMALL_VAL   = 1;
    localparam int BIG_VAL_DEF = 2;
    localparam int TMO_DEF     = 15;

    typedef enum logic [6:0] {
        ST_IDLE     = 7'b000_0001,
        ST_SEL      = 7'b000_0010,
        ST_EJ_BIG   = 7'b000_0100,
        ST_EJ_SMALL = 7'b000_1000,
        ST_WAIT_LOW = 7'b001_0000,
        ST_DONE     = 7'b010_0000,
        ST_ERR      = 7'b100_0000
    } state_t;

endpackage

// File: rtl/vend_ack_timer.sv
// Saturating per-state cycle counter for hopper handshake timeouts.
// hit is asserted while the count sits at TMO.
module vend_ack_timer
    import vend_pkg::*;
#(
    parameter int TMO = TMO_DEF,
    parameter int CW  = $clog2(TMO + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          hit
);

    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != TMO_C)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign hit = (count_reg == TMO_C);

endmodule

// File: rtl/vend_payout.sv
// Greedy change dispenser: pays an amount in half-units as big then small coins,
// one req/ack handshake per coin, with a sticky timeout error.
module vend_payout
    import vend_pkg::*;
#(
    parameter int AMT_W   = AMT_W_DEF,
    parameter int BIG_VAL = BIG_VAL_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pay_req,
    input  logic [AMT_W-1:0] pay_amt,
    input  logic             eject_ack,
    output logic             eject_big,
    output logic             eject_small,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [AMT_W-1:0] BIG_AMT   = AMT_W'(BIG_VAL);
    localparam logic [AMT_W-1:0] SMALL_AMT = AMT_W'(SMALL_VAL);

    state_t           state_reg, state_next;
    logic [AMT_W-1:0] remaining_reg, remaining_next;
    logic             eject_big_reg, eject_big_next;
    logic             eject_small_reg, eject_small_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             tmr_clr, tmr_en, tmr_hit;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            remaining_reg   <= '0;
            eject_big_reg   <= 1'b0;
            eject_small_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            remaining_reg   <= remaining_next;
            eject_big_reg   <= eject_big_next;
            eject_small_reg <= eject_small_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end

    // Next-state and remaining-amount logic
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pay_req && !err_reg) begin
                    if (pay_amt == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        remaining_next = pay_amt;
                        state_next     = ST_SEL;
                    end
                end
            end
            ST_SEL: begin
                if (remaining_reg >= BIG_AMT) begin
                    state_next = ST_EJ_BIG;
                end else if (remaining_reg != '0) begin
                    state_next = ST_EJ_SMALL;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_EJ_BIG: begin
                if (eject_ack) begin
                    remaining_next = remaining_reg - BIG_AMT;
                    state_next     = ST_WAIT_LOW;
                end else if (tmr_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_EJ_SMALL: begin
                if (eject_ack) begin
                    remaining_next = remaining_reg - SMALL_AMT;
                    state_next     = ST_WAIT_LOW;
                end else if (tmr_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_WAIT_LOW: begin
                if (!eject_ack) begin
                    state_next = ST_SEL;
                end else if (tmr_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                remaining_next = '0;
                state_next     = ST_IDLE;
            end
            default: begin
                remaining_next = '0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the current state and registered, so they lag it by one cycle
    always_comb begin
        eject_big_next   = (state_reg == ST_EJ_BIG);
        eject_small_next = (state_reg == ST_EJ_SMALL);
        busy_next        = state_reg inside {ST_SEL, ST_EJ_BIG, ST_EJ_SMALL, ST_WAIT_LOW};
        done_next        = (state_reg == ST_DONE);
        err_next         = err_reg | (state_reg == ST_ERR);
    end

    // Timer restarts on every state change and runs only while waiting on the hopper
    assign tmr_en  = state_reg inside {ST_EJ_BIG, ST_EJ_SMALL, ST_WAIT_LOW};
    assign tmr_clr = (state_next != state_reg);

    vend_ack_timer #(
        .TMO (TMO),
        .CW  (CW)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .load     (1'b0),
        .load_val ('0),
        .hit      (tmr_hit)
    );

    assign eject_big   = eject_big_reg;
    assign eject_small = eject_small_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_vend_payout.sv
// Randomized bench for vend_payout: a hopper model answers eject requests and a
// monitor records the coin sequence, compared against greedy change arithmetic.
module tb_vend_payout;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pay_req = 1'b0;
    logic [3:0] pay_amt = 4'd0;
    logic       eject_ack = 1'b0;
    logic       eject_big, eject_small, busy, done, err;

    int checks = 0;
    int failures = 0;

    // monitor state
    int big_cnt, small_cnt, done_cnt, both_cnt, done_busy_cnt, busy_cnt, big_hi, seq_code;
    logic prev_big = 1'b0;
    logic prev_small = 1'b0;

    // hopper model: 0 random delays, 1 fixed delays, 2 never acks
    int hop_mode = 0;
    int fix_d1 = 0;
    int fix_d2 = 0;
    int h_st = 0;
    int h_cnt = 0;

    bit ok;

    vend_payout dut (
        .clk         (clk),
        .rst         (rst),
        .pay_req     (pay_req),
        .pay_amt     (pay_amt),
        .eject_ack   (eject_ack),
        .eject_big   (eject_big),
        .eject_small (eject_small),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eject_big && !prev_big) begin
            big_cnt++;
            seq_code = seq_code * 3 + 2;
        end
        if (eject_small && !prev_small) begin
            small_cnt++;
            seq_code = seq_code * 3 + 1;
        end
        if (eject_big && eject_small) both_cnt++;
        if (done) begin
            done_cnt++;
            if (busy) done_busy_cnt++;
        end
        if (busy) busy_cnt++;
        if (eject_big) big_hi++;
        prev_big = eject_big;
        prev_small = eject_small;
    end

    always @(negedge clk) begin
        if (!rst) begin
            eject_ack = 1'b0;
            h_st = 0;
        end else begin
            case (h_st)
                0: if ((eject_big || eject_small) && hop_mode != 2) begin
                    h_cnt = (hop_mode == 1) ? fix_d1 : int'($urandom_range(0, 6));
                    h_st = 1;
                end
                1: if (h_cnt == 0) begin
                    eject_ack = 1'b1;
                    h_st = 2;
                end else h_cnt--;
                2: if (!eject_big && !eject_small) begin
                    h_cnt = (hop_mode == 1) ? fix_d2 : int'($urandom_range(0, 6));
                    h_st = 3;
                end
                default: if (h_cnt == 0) begin
                    eject_ack = 1'b0;
                    h_st = 0;
                end else h_cnt--;
            endcase
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // greedy change: all big coins first, then one small coin for an odd half-unit
    function automatic int ref_code(input int amt);
        int code = 0;
        for (int i = 0; i < amt / 2; i++) code = code * 3 + 2;
        if (amt % 2 == 1) code = code * 3 + 1;
        return code;
    endfunction

    task automatic clr_mon();
        big_cnt = 0; small_cnt = 0; done_cnt = 0; both_cnt = 0;
        done_busy_cnt = 0; busy_cnt = 0; big_hi = 0; seq_code = 0;
    endtask

    task automatic pulse(input int amt);
        @(negedge clk);
        pay_req = 1'b1;
        pay_amt = 4'(amt);
        @(negedge clk);
        pay_req = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit fin);
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                fin = 1'b1;
                break;
            end
        end
        #2;
    endtask

    task automatic wait_big(input int budget, output bit fin);
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (eject_big) begin
                fin = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic check_payout(input string pfx, input int amt);
        chk({pfx, "_seq"}, seq_code, ref_code(amt));
        chk({pfx, "_done_cnt"}, done_cnt, 1);
        chk({pfx, "_both_eject"}, both_cnt, 0);
        chk({pfx, "_busy_with_done"}, done_busy_cnt, 0);
        chk({pfx, "_err"}, int'(err), 0);
        $display("TXN %s amt=%0d big=%0d small=%0d done=%0d err=%0d",
                 pfx, amt, big_cnt, small_cnt, done_cnt, err);
    endtask

    initial begin
        clr_mon();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_eject_big", int'(eject_big), 0);
        chk("rst_eject_small", int'(eject_small), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // amount 3 with fixed hopper timing, including request-to-eject latency
        hop_mode = 1; fix_d1 = 2; fix_d2 = 1;
        clr_mon();
        pulse(3);
        chk("t1_lat_k0", int'(eject_big), 0);
        @(negedge clk);
        chk("t1_lat_k1", int'(eject_big), 0);
        @(negedge clk);
        chk("t1_lat_k2", int'(eject_big), 1);
        wait_end(400, ok);
        chk("t1_finished", int'(ok), 1);
        settle();
        check_payout("t1", 3);

        // zero amount: done on the cycle after the request, no coins, never busy
        hop_mode = 0;
        clr_mon();
        pulse(0);
        chk("t2_done_k0", int'(done), 0);
        @(negedge clk);
        chk("t2_done_k1", int'(done), 1);
        @(negedge clk);
        chk("t2_done_k2", int'(done), 0);
        settle();
        chk("t2_busy_cycles", busy_cnt, 0);
        chk("t2_coins", big_cnt + small_cnt, 0);
        chk("t2_done_cnt", done_cnt, 1);
        $display("TXN t2 amt=0 big=%0d small=%0d done=%0d", big_cnt, small_cnt, done_cnt);

        // maximum amount
        clr_mon();
        pulse(15);
        wait_end(400, ok);
        chk("t3_finished", int'(ok), 1);
        settle();
        check_payout("t3", 15);

        // random amounts and random hopper delays
        for (int n = 0; n < 12; n++) begin
            int amt;
            amt = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            clr_mon();
            pulse(amt);
            wait_end(400, ok);
            chk("t4_finished", int'(ok), 1);
            settle();
            check_payout($sformatf("t4_%0d", n), amt);
        end

        // second request during the first coin is ignored
        clr_mon();
        pulse(6);
        wait_big(40, ok);
        chk("t5_first_eject", int'(ok), 1);
        pulse(2);
        wait_end(400, ok);
        chk("t5_finished", int'(ok), 1);
        settle();
        check_payout("t5", 6);

        // hopper never acks: timeout after TMO+1 cycles of eject, sticky error
        hop_mode = 2;
        clr_mon();
        pulse(4);
        wait_end(100, ok);
        chk("t6_finished", int'(ok), 1);
        repeat (2) @(negedge clk);
        #2;
        chk("t6_eject_cycles", big_hi, TMO + 1);
        chk("t6_err", int'(err), 1);
        chk("t6_eject_low", int'(eject_big), 0);
        chk("t6_no_done", done_cnt, 0);
        $display("TXN t6 amt=4 eject_cycles=%0d err=%0d", big_hi, err);
        clr_mon();
        pulse(5);
        repeat (40) @(negedge clk);
        #2;
        chk("t6_ignored_coins", big_cnt + small_cnt, 0);
        chk("t6_ignored_done", done_cnt, 0);
        chk("t6_ignored_busy", busy_cnt, 0);
        chk("t6_err_sticky", int'(err), 1);
        $display("TXN t6b amt=5 coins=%0d done=%0d err=%0d", big_cnt + small_cnt, done_cnt, err);

        // reset clears the sticky error; then reset in the middle of a handshake
        hop_mode = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_err_cleared", int'(err), 0);
        clr_mon();
        pulse(5);
        wait_big(40, ok);
        chk("t7_first_eject", int'(ok), 1);
        #3 rst = 1'b0;
        #1;
        chk("t7_async_eject", int'(eject_big), 0);
        chk("t7_async_busy", int'(busy), 0);
        chk("t7_async_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        clr_mon();
        pulse(1);
        wait_end(400, ok);
        chk("t7_finished", int'(ok), 1);
        settle();
        check_payout("t7", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
